// File: rtl/mips_pkg.sv
// Shared write-back types and default widths for the register-file write buffer.
package mips_pkg;

  localparam int WB_DEPTH  = 4;
  localparam int WB_ADDR_W = 5;
  localparam int WB_DATA_W = 32;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] rd;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_match.sv
// Youngest-entry search for one source register over the pending-write ring.
module wb_match
  import mips_pkg::*;
#(
  parameter int DEPTH  = WB_DEPTH,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DATA_W = WB_DATA_W
) (
  input  logic [ADDR_W-1:0]      rs,
  input  logic [$clog2(DEPTH)-1:0] rd_ptr,
  input  logic [$clog2(DEPTH):0] count,
  input  logic [ADDR_W-1:0]      ent_reg  [DEPTH],
  input  logic [DATA_W-1:0]      ent_data [DEPTH],
  output logic                   hit,
  output logic [DATA_W-1:0]      data
);

  localparam int PTR_W = $clog2(DEPTH);

  // Walk from oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    logic [PTR_W-1:0] idx;
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PTR_W'(k);
      if ((k < int'(count)) && (rs != '0) && (ent_reg[idx] == rs)) begin
        hit  = 1'b1;
        data = ent_data[idx];
      end
    end
  end

endmodule

// File: rtl/wb_buffer.sv
// Pending register-file write queue with per-source pending/forwarding lookup.
// Define WB_BUFFER_BYPASS_EN to drive fwd_hit/fwd_data from the youngest match.
module wb_buffer
  import mips_pkg::*;
#(
  parameter int DEPTH  = WB_DEPTH,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DATA_W = WB_DATA_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ADDR_W-1:0]      in_reg,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   flush,
  input  logic                   rf_hold,
  output logic                   rf_we,
  output logic [ADDR_W-1:0]      rf_waddr,
  output logic [DATA_W-1:0]      rf_wdata,
  input  logic [ADDR_W-1:0]      rs1,
  input  logic [ADDR_W-1:0]      rs2,
  output logic                   pend1,
  output logic                   pend2,
  output logic                   fwd_hit1,
  output logic                   fwd_hit2,
  output logic [DATA_W-1:0]      fwd_data1,
  output logic [DATA_W-1:0]      fwd_data2,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

`ifdef WB_BUFFER_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  logic [ADDR_W-1:0] ent_reg  [DEPTH];
  logic [DATA_W-1:0] ent_data [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] match_data1;
  logic [DATA_W-1:0] match_data2;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign rf_we    = !empty && !rf_hold && !flush;
  assign pop      = rf_we;
  // Writes to r0 are consumed but never stored; flush wins over a push.
  assign push     = in_valid && in_ready && (in_reg != '0) && !flush;
  assign rf_waddr = empty ? '0 : ent_reg[rd_ptr];
  assign rf_wdata = empty ? '0 : ent_data[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ent_reg[wr_ptr]  <= in_reg;
      ent_data[wr_ptr] <= in_data;
    end
  end

  wb_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_match1 (
    .rs       (rs1),
    .rd_ptr   (rd_ptr),
    .count    (count),
    .ent_reg  (ent_reg),
    .ent_data (ent_data),
    .hit      (pend1),
    .data     (match_data1)
  );

  wb_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_match2 (
    .rs       (rs2),
    .rd_ptr   (rd_ptr),
    .count    (count),
    .ent_reg  (ent_reg),
    .ent_data (ent_data),
    .hit      (pend2),
    .data     (match_data2)
  );

  assign fwd_hit1  = BYPASS_EN && pend1;
  assign fwd_hit2  = BYPASS_EN && pend2;
  assign fwd_data1 = BYPASS_EN ? match_data1 : '0;
  assign fwd_data2 = BYPASS_EN ? match_data2 : '0;

endmodule

// File: tb/tb_wb_buffer.sv
// Directed bench for wb_buffer; expected register-file writes flow through a scoreboard queue.
module tb_wb_buffer;
  import mips_pkg::*;

`ifdef WB_BUFFER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_reg;
  logic [31:0] in_data;
  logic        flush;
  logic        rf_hold;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        pend1;
  logic        pend2;
  logic        fwd_hit1;
  logic        fwd_hit2;
  logic [31:0] fwd_data1;
  logic [31:0] fwd_data2;
  logic [2:0]  count;

  wb_entry_t sb[$];
  int total = 0;
  int bad   = 0;

  wb_buffer #(.DEPTH(4), .ADDR_W(5), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_reg    (in_reg),
    .in_data   (in_data),
    .flush     (flush),
    .rf_hold   (rf_hold),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .rs1       (rs1),
    .rs2       (rs2),
    .pend1     (pend1),
    .pend2     (pend2),
    .fwd_hit1  (fwd_hit1),
    .fwd_hit2  (fwd_hit2),
    .fwd_data1 (fwd_data1),
    .fwd_data2 (fwd_data2),
    .count     (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic v, input logic [4:0] r, input logic [31:0] d,
                                input logic enq);
    wb_entry_t e;
    in_valid = v;
    in_reg   = r;
    in_data  = d;
    if (enq) begin
      e.rd   = r;
      e.data = d;
      sb.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int max_cycles);
    int n;
    n = 0;
    while (sb.size() != 0 && n < max_cycles) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_output("drain_done", sb.size(), 32'd0);
  endtask

  // Monitor: every register-file write must match the oldest expected entry.
  initial begin
    forever begin
      @(negedge clk);
      if (rf_we === 1'b1) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_write actual=r%0d/0x%0h required=no write",
                   rf_waddr, rf_wdata);
        end else begin
          wb_entry_t e;
          e = sb.pop_front();
          check_output("rf_waddr", 32'(rf_waddr), 32'(e.rd));
          check_output("rf_wdata", rf_wdata, e.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_reg = '0; in_data = '0;
    flush = 1'b0; rf_hold = 1'b0; rs1 = '0; rs2 = '0;

    // Reset state
    @(negedge clk);
    check_output("rst_count", 32'(count), 32'd0);
    check_output("rst_in_ready", 32'(in_ready), 32'd1);
    check_output("rst_rf_we", 32'(rf_we), 32'd0);
    check_output("rst_pend1", 32'(pend1), 32'd0);
    check_output("rst_fwd_hit1", 32'(fwd_hit1), 32'd0);
    check_output("rst_waddr", 32'(rf_waddr), 32'd0);
    step();
    rst = 1'b0;

    // Single push, one-cycle latency to the register file
    apply_stimulus(1'b1, 5'd5, 32'h11, 1'b1);
    step();
    apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0);
    @(negedge clk);
    check_output("t1_rf_we", 32'(rf_we), 32'd1);
    check_output("t1_count", 32'(count), 32'd1);
    step();
    @(negedge clk);
    check_output("t1_count_after", 32'(count), 32'd0);
    check_output("t1_rf_we_after", 32'(rf_we), 32'd0);

    // Fill under hold, fifth push stalls, then drain in order
    step();
    rf_hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      apply_stimulus(1'b1, 5'(i), 32'(256 + i), 1'b1);
      step();
    end
    apply_stimulus(1'b1, 5'd6, 32'h106, 1'b1);
    @(negedge clk);
    check_output("t2_in_ready_full", 32'(in_ready), 32'd0);
    check_output("t2_count_full", 32'(count), 32'd4);
    check_output("t2_rf_we_hold", 32'(rf_we), 32'd0);
    step();
    rf_hold = 1'b0;
    @(negedge clk);
    check_output("t2_count_stall", 32'(count), 32'd4);
    check_output("t2_no_passthru", 32'(in_ready), 32'd0);
    step();
    @(negedge clk);
    check_output("t2_count_pop", 32'(count), 32'd3);
    check_output("t2_in_ready_pop", 32'(in_ready), 32'd1);
    step();
    apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0);
    wait_drain(10);
    step();
    @(negedge clk);
    check_output("t2_count_drained", 32'(count), 32'd0);

    // Pending / youngest-match forwarding
    step();
    rf_hold = 1'b1;
    apply_stimulus(1'b1, 5'd3, 32'hA, 1'b1);
    step();
    apply_stimulus(1'b1, 5'd3, 32'hB, 1'b1);
    step();
    apply_stimulus(1'b1, 5'd7, 32'hD, 1'b1);
    step();
    apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0);
    rs1 = 5'd3;
    rs2 = 5'd7;
    @(negedge clk);
    check_output("t3_count", 32'(count), 32'd3);
    check_output("t3_pend1", 32'(pend1), 32'd1);
    check_output("t3_fwd_hit1", 32'(fwd_hit1), 32'(BYP));
    check_output("t3_fwd_data1", fwd_data1, BYP ? 32'hB : 32'h0);
    check_output("t3_pend2", 32'(pend2), 32'd1);
    check_output("t3_fwd_data2", fwd_data2, BYP ? 32'hD : 32'h0);
    step();
    rs1 = 5'd9;
    rs2 = 5'd0;
    @(negedge clk);
    check_output("t3_pend1_miss", 32'(pend1), 32'd0);
    check_output("t3_pend2_r0", 32'(pend2), 32'd0);
    check_output("t3_fwd_hit1_miss", 32'(fwd_hit1), 32'd0);
    step();
    rs1 = 5'd0;
    rf_hold = 1'b0;
    wait_drain(10);
    step();
    @(negedge clk);
    check_output("t3_count_drained", 32'(count), 32'd0);

    // Writes to r0 are swallowed
    step();
    apply_stimulus(1'b1, 5'd0, 32'h55, 1'b0);
    @(negedge clk);
    check_output("t4_in_ready", 32'(in_ready), 32'd1);
    step();
    apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0);
    @(negedge clk);
    check_output("t4_count", 32'(count), 32'd0);
    check_output("t4_rf_we", 32'(rf_we), 32'd0);

    // Flush with a simultaneous push
    step();
    rf_hold = 1'b1;
    apply_stimulus(1'b1, 5'd8, 32'h80, 1'b1);
    step();
    apply_stimulus(1'b1, 5'd9, 32'h90, 1'b1);
    step();
    apply_stimulus(1'b1, 5'd10, 32'hA0, 1'b1);
    step();
    sb.delete();
    flush = 1'b1;
    rf_hold = 1'b0;
    apply_stimulus(1'b1, 5'd11, 32'h77, 1'b0);
    @(negedge clk);
    check_output("t5_rf_we_flush", 32'(rf_we), 32'd0);
    check_output("t5_count_pre", 32'(count), 32'd3);
    step();
    flush = 1'b0;
    apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0);
    @(negedge clk);
    check_output("t5_count_post", 32'(count), 32'd0);
    check_output("t5_rf_we_post", 32'(rf_we), 32'd0);
    check_output("t5_in_ready_post", 32'(in_ready), 32'd1);

    // Reset in the middle of a drain
    step();
    rf_hold = 1'b1;
    apply_stimulus(1'b1, 5'd12, 32'hC0, 1'b1);
    step();
    apply_stimulus(1'b1, 5'd13, 32'hD0, 1'b1);
    step();
    apply_stimulus(1'b1, 5'd14, 32'hE0, 1'b1);
    step();
    apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0);
    rf_hold = 1'b0;
    rs1 = 5'd13;
    @(negedge clk);
    check_output("t6_pend1_pre", 32'(pend1), 32'd1);
    step();
    sb.delete();
    rst = 1'b1;
    #1;
    check_output("t6_rf_we_rst", 32'(rf_we), 32'd0);
    check_output("t6_count_rst", 32'(count), 32'd0);
    check_output("t6_in_ready_rst", 32'(in_ready), 32'd1);
    check_output("t6_pend1_rst", 32'(pend1), 32'd0);
    #2;
    rst = 1'b0;
    rs1 = 5'd0;
    @(negedge clk);
    check_output("t6_count_after", 32'(count), 32'd0);
    check_output("t6_rf_we_after", 32'(rf_we), 32'd0);

    step();
    check_output("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_buffer.md
WB_BUFFER -- requirements
Module: wb_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning pending-write queue entries (power of 2, 2..16).
REQ-002 SHALL have parameter ADDR_W, default 5, meaning register index width.
REQ-003 SHALL have parameter DATA_W, default 32, meaning register data width.
REQ-004 SHALL have port clk  in  1  clock; all state updates on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port in_valid  in  1  result offered by datapath.
REQ-007 SHALL have port in_ready  out  1  buffer can accept a result.
REQ-008 SHALL have port in_reg  in  ADDR_W  destination register of offered result.
REQ-009 SHALL have port in_data  in  DATA_W  offered result value.
REQ-010 SHALL have port flush  in  1  discard all pending writes.
REQ-011 SHALL have port rf_hold  in  1  register file write port unavailable this cycle.
REQ-012 SHALL have port rf_we  out  1  write enable to register file.
REQ-013 SHALL have port rf_waddr  out  ADDR_W  write register index.
REQ-014 SHALL have port rf_wdata  out  DATA_W  write data.
REQ-015 SHALL have ports rs1, rs2  in  ADDR_W each  source indices under lookup.
REQ-016 SHALL have ports pend1, pend2  out  1 each  source has a queued write.
REQ-017 SHALL have ports fwd_hit1, fwd_hit2  out  1 each; fwd_data1, fwd_data2  out  DATA_W each  forwarded value.
REQ-018 SHALL have port count  out  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-019 SHALL operate as a FIFO of (reg, data) entries; in_ready = !full, independent of in_valid.
REQ-020 SHALL accept on in_valid && in_ready at the clock edge; in_reg == 0 SHALL be consumed but not enqueued.
REQ-021 SHALL drive rf_we = !empty && !rf_hold && !flush combinationally; rf_waddr/rf_wdata SHALL show the head entry, and be zero when empty.
REQ-022 SHALL pop the head at each edge where rf_we = 1; at most one write per cycle.
REQ-023 SHALL give a minimum latency of 1: result accepted at edge N appears on rf port in cycle N+1.
REQ-024 SHALL allow simultaneous push and pop when not full; count unchanged; when full, pop in the same cycle SHALL NOT raise in_ready (no pass-through).
REQ-025 SHALL wrap read/write pointers modulo DEPTH with no lost or duplicated entry.
REQ-026 SHALL clear all entries at an edge with flush = 1; flush SHALL override a simultaneous push and suppress rf_we in that cycle.
REQ-027 SHALL assert pendX combinationally when any valid entry has reg == rsX; rsX == 0 SHALL never be pending.
REQ-028 SHALL keep the queue and outputs unchanged while rf_hold = 1, except for pushes.

Reset
REQ-029 SHALL on rst empty the queue, zero pointers and count; in_ready = 1, rf_we = 0, pend/fwd outputs = 0.
REQ-030 SHALL discard a push coinciding with rst deassertion edge only if rst is still sampled high.

Configuration
REQ-031 SHALL compile forwarding with macro WB_BUFFER_BYPASS_EN: when defined, fwd_hitX = pendX and fwd_dataX = data of the youngest matching entry.
REQ-032 SHALL, without WB_BUFFER_BYPASS_EN, tie fwd_hitX and fwd_dataX to zero; pendX remains functional.

Structure
REQ-033 SHALL place the entry struct (reg, data) and default width constants in shared package mips_pkg.
REQ-034 SHALL implement the youngest-match search in one sub-module wb_match, instantiated once per source port.

Verification
REQ-035 SHALL test: push (r5, 0x11) into empty buffer, rf_hold = 0 -> next cycle rf_we = 1, waddr 5, wdata 0x11; count returns to 0.
REQ-036 SHALL test: rf_hold = 1, push 4 entries -> in_ready = 0, count = 4; fifth push stalls; release hold -> 4 writes in order over 4 cycles.
REQ-037 SHALL test: queue (r3, 0xA) then (r3, 0xB), rs1 = 3 -> pend1 = 1; fwd_data1 = 0xB with WB_BUFFER_BYPASS_EN, 0 without.
REQ-038 SHALL test: push in_reg = 0 with in_valid = 1 -> in_ready stays 1, count stays 0, no rf_we.
REQ-039 SHALL test: 3 entries queued, flush with simultaneous push -> next cycle count = 0, rf_we = 0 in flush cycle.
REQ-040 SHALL test: rst asserted mid-drain -> rf_we drops immediately, count = 0, in_ready = 1.
